// File: rtl/mc_pkg.sv
// Shared definitions for the fetch/dispatch sequencer and the execution FSMs:
// sequencer state encoding, opcode values and the opcode-to-start mapping.
package mc_pkg;

  // Opcode occupies the top nibble of the instruction word.
  localparam int OPC_W    = 4;
  // Number of execution FSMs addressed by the one-hot start mapping.
  localparam int EXEC_OPS = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    DECODE,
    DISPATCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [OPC_W-1:0] OPC_NOP     = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ALU_IMM = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ALU_REG = 4'h2;
  localparam logic [OPC_W-1:0] OPC_LOAD    = 4'h3;
  localparam logic [OPC_W-1:0] OPC_STORE   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_HALT    = 4'hF;

  // Opcode -> one-hot start vector. Zero means "no execution FSM owns this
  // opcode" (NOP, HALT or undefined). Execution FSMs index the same table.
  localparam logic [EXEC_OPS-1:0] OPC_ONEHOT [16] = '{
    4'b0000,  // 0 NOP
    4'b0001,  // 1 ALU_IMM
    4'b0010,  // 2 ALU_REG
    4'b0100,  // 3 LOAD
    4'b1000,  // 4 STORE
    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
    4'b0000   // F HALT
  };

  // An opcode is legal if it dispatches to an FSM or is handled in-line.
  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    return (OPC_ONEHOT[opc] != '0) || (opc == OPC_NOP) || (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: ADDR_W-bit register with synchronous load, increment and
// asynchronous active-low clear. Wraps modulo 2^ADDR_W silently.
module pc_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority over increment.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for state so all flops update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Instruction fetch/decode sequencer. Fetches a word at the PC into the
// instruction register, decodes the opcode, pulses a one-hot start to the
// matching execution FSM and waits for its done before fetching again.
// Optional EXEC watchdog: define FDC_WATCHDOG_EN to enable it.
module fetch_dispatch_ctrl
  import mc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int NUM_OPS  = 4,
  parameter int WDOG_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  pc_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [NUM_OPS-1:0] op_start,
  input  logic               op_done,
  input  logic               pc_inc,
  output logic               halted,
  output logic               illegal
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 illegal_q, illegal_d;
  logic                 pc_adv;
  logic                 wdog_trip;
  logic [OPC_W-1:0]     opc;

  assign opc = ir_q[INSTR_W-1 -: OPC_W];

  // PC advances on instruction capture and on operand consumption in EXEC;
  // pc_inc arriving in any other state is ignored.
  assign pc_adv = ((state_q == WAIT_MEM) && mem_valid) ||
                  ((state_q == EXEC) && pc_inc);

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (pc_adv),
    .cnt      (pc_addr)
  );

`ifdef FDC_WATCHDOG_EN
  logic [7:0] wdog_q, wdog_d;

  // Watchdog count: cleared at dispatch, counts every EXEC cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == DISPATCH) begin
      wdog_d = '0;
    end else if (state_q == EXEC) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  // Trips on the EXEC cycle in which the count reaches WDOG_MAX.
  assign wdog_trip = (state_q == EXEC) && (wdog_q == 8'(WDOG_MAX - 1));

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // State register plus instruction and sticky-illegal registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic, instruction capture and illegal-opcode detection.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        state_d = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          ir_d    = mem_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opc == OPC_NOP) begin
          state_d = run ? FETCH : IDLE;
        end else if (opc == OPC_HALT) begin
          state_d = HALT;
        end else if (!opc_is_legal(opc)) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else begin
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        // run is only consulted here and in DECODE, so a stop request never
        // cuts an instruction short.
        if (op_done) begin
          state_d = run ? FETCH : IDLE;
        end else if (wdog_trip) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    mem_rd   = (state_q == FETCH) || (state_q == WAIT_MEM);
    halted   = (state_q == HALT);
    op_start = '0;
    if (state_q == DISPATCH) begin
      op_start = NUM_OPS'(OPC_ONEHOT[opc]);
    end
  end

  assign ir      = ir_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Self-checking bench for fetch_dispatch_ctrl: table of single-instruction
// programs plus directed multi-cycle sequences (async reset, NOP skip,
// illegal halt, PC wrap, EXEC watchdog when FDC_WATCHDOG_EN is defined).
module tb_fetch_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_rd;
  logic [7:0]  pc_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] ir;
  logic [3:0]  op_start;
  logic        op_done;
  logic        pc_inc;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  fetch_dispatch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_rd    (mem_rd),
    .pc_addr   (pc_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .ir        (ir),
    .op_start  (op_start),
    .op_done   (op_done),
    .pc_inc    (pc_inc),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Program memory: data valid exactly one cycle after a read request.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
    end else begin
      mem_valid <= mem_rd && !mem_valid;
      mem_data  <= mem[pc_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Fill memory with HALT so runaway fetches stop, then reset the DUT.
  task automatic do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    run = 1'b0; op_done = 1'b0; pc_inc = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Bounded wait for an op_start pulse or HALT; cyc = cycles waited.
  task automatic wait_event(input string tag, input int budget,
                            output int cyc, output logic [3:0] seen);
    cyc = 0;
    while (cyc < budget && op_start == 4'b0000 && !halted) begin
      tick();
      cyc++;
    end
    seen = op_start;
    check({tag, "_wait_timeout"}, 32'(cyc >= budget), 32'd0);
  endtask

  typedef struct {
    logic [15:0] instr;
    int          n_inc;
    logic [3:0]  exp_start;
    logic        exp_illegal;
    logic        exp_halted;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         cyc;
    logic [3:0] seen;
    logic [3:0] acc_start;
    logic       acc_rd;

    vecs[0] = '{16'h1005, 1, 4'b0001, 1'b0, 1'b0, 8'h02};
    vecs[1] = '{16'h2ABC, 0, 4'b0010, 1'b0, 1'b0, 8'h01};
    vecs[2] = '{16'h3001, 2, 4'b0100, 1'b0, 1'b0, 8'h03};
    vecs[3] = '{16'h4000, 3, 4'b1000, 1'b0, 1'b0, 8'h04};
    vecs[4] = '{16'h7ABC, 0, 4'b0000, 1'b1, 1'b1, 8'h01};
    vecs[5] = '{16'h5000, 0, 4'b0000, 1'b1, 1'b1, 8'h01};
    vecs[6] = '{16'hE123, 0, 4'b0000, 1'b1, 1'b1, 8'h01};
    vecs[7] = '{16'hF000, 0, 4'b0000, 1'b0, 1'b1, 8'h01};

    // ---- reset state ----
    do_reset();
    check("rst_pc",       32'(pc_addr),  32'h0);
    check("rst_ir",       32'(ir),       32'h0);
    check("rst_mem_rd",   32'(mem_rd),   32'h0);
    check("rst_op_start", 32'(op_start), 32'h0);
    check("rst_halted",   32'(halted),   32'h0);
    check("rst_illegal",  32'(illegal),  32'h0);

    // ---- table: one instruction at address 0 ----
    for (int v = 0; v < 8; v++) begin
      do_reset();
      mem[0] = vecs[v].instr;
      run = 1'b1;
      tick();                                   // FETCH
      check($sformatf("v%0d_fetch_rd", v), 32'(mem_rd), 32'h1);
      wait_event($sformatf("v%0d", v), 20, cyc, seen);
      check($sformatf("v%0d_op_start", v), 32'(seen), 32'(vecs[v].exp_start));
      if (vecs[v].exp_start != 4'b0000) begin
        // FETCH, WAIT_MEM, DECODE, DISPATCH: start in the 4th cycle.
        check($sformatf("v%0d_latency", v), 32'(cyc + 1), 32'd4);
        check($sformatf("v%0d_ir", v), 32'(ir), 32'(vecs[v].instr));
        tick();                                 // EXEC
        check($sformatf("v%0d_one_cycle", v), 32'(op_start), 32'h0);
        for (int k = 0; k < vecs[v].n_inc; k++) begin
          pc_inc = 1'b1;
          tick();
          pc_inc = 1'b0;
        end
        tick();
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check($sformatf("v%0d_refetch_rd", v), 32'(mem_rd), 32'h1);
      end
      check($sformatf("v%0d_pc", v),      32'(pc_addr), 32'(vecs[v].exp_pc));
      check($sformatf("v%0d_illegal", v), 32'(illegal), 32'(vecs[v].exp_illegal));
      check($sformatf("v%0d_halted", v),  32'(halted),  32'(vecs[v].exp_halted));
    end

    // ---- async reset in the middle of EXEC ----
    do_reset();
    mem[0] = 16'h1005;
    run = 1'b1;
    wait_event("arst", 20, cyc, seen);
    tick();                                     // EXEC
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("arst_pre_pc", 32'(pc_addr), 32'h2);
    #2;
    reset = 1'b0;
    run = 1'b0;
    #1;                                         // still before the next edge
    check("arst_pc",       32'(pc_addr),  32'h0);
    check("arst_op_start", 32'(op_start), 32'h0);
    check("arst_mem_rd",   32'(mem_rd),   32'h0);
    check("arst_ir",       32'(ir),       32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("arst_idle_rd", 32'(mem_rd), 32'h0);

    // ---- NOP then STORE; stop requested mid-STORE ----
    do_reset();
    mem[0] = 16'h0000;
    mem[1] = 16'h4000;
    run = 1'b1;
    wait_event("nop", 30, cyc, seen);
    check("nop_first_start", 32'(seen),    32'b1000);
    check("nop_store_ir",    32'(ir),      32'h4000);
    check("nop_store_pc",    32'(pc_addr), 32'h2);
    tick();                                     // EXEC
    run = 1'b0;
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("nop_done_pc",   32'(pc_addr), 32'h2);
    check("nop_stop_idle", 32'(mem_rd),  32'h0);
    run = 1'b1;
    tick();
    check("nop_restart_rd", 32'(mem_rd), 32'h1);

    // ---- illegal opcode halts; later inputs have no effect ----
    do_reset();
    mem[0] = 16'h7ABC;
    run = 1'b1;
    wait_event("ill", 20, cyc, seen);
    check("ill_start",   32'(seen),    32'h0);
    check("ill_illegal", 32'(illegal), 32'h1);
    check("ill_halted",  32'(halted),  32'h1);
    acc_start = '0;
    acc_rd    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run     = i[0];
      op_done = i[1];
      pc_inc  = ~i[0];
      tick();
      acc_start |= op_start;
      acc_rd    |= mem_rd;
    end
    run = 1'b0; op_done = 1'b0; pc_inc = 1'b0;
    check("ill_hold_start",   32'(acc_start), 32'h0);
    check("ill_hold_rd",      32'(acc_rd),    32'h0);
    check("ill_hold_pc",      32'(pc_addr),   32'h1);
    check("ill_hold_halted",  32'(halted),    32'h1);
    check("ill_hold_illegal", 32'(illegal),   32'h1);

    // ---- PC wrap at 0xFF, pc_inc and op_done together ----
    do_reset();
    mem[0]     = 16'h1000;
    mem[8'hFF] = 16'h1000;
    run = 1'b1;
    wait_event("wrap_a", 20, cyc, seen);
    tick();                                     // EXEC
    pc_inc = 1'b1;
    repeat (254) tick();
    pc_inc = 1'b0;
    check("wrap_pc_ff", 32'(pc_addr), 32'hFF);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    wait_event("wrap_b", 20, cyc, seen);
    check("wrap_start", 32'(seen),    32'b0001);
    check("wrap_pc_00", 32'(pc_addr), 32'h00);
    tick();                                     // EXEC
    pc_inc  = 1'b1;
    op_done = 1'b1;
    tick();
    pc_inc  = 1'b0;
    op_done = 1'b0;
    check("wrap_pc_01",  32'(pc_addr), 32'h01);
    check("wrap_both_rd", 32'(mem_rd), 32'h1);

    // ---- EXEC with op_done withheld ----
    do_reset();
    mem[0] = 16'h2000;
    run = 1'b1;
    wait_event("wdog", 20, cyc, seen);
    repeat (300) tick();
`ifdef FDC_WATCHDOG_EN
    check("wdog_illegal", 32'(illegal), 32'h1);
    check("wdog_halted",  32'(halted),  32'h1);
`else
    check("wdog_off_halted",  32'(halted),  32'h0);
    check("wdog_off_illegal", 32'(illegal), 32'h0);
    check("wdog_off_rd",      32'(mem_rd),  32'h0);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("wdog_off_done_rd", 32'(mem_rd), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_dispatch_ctrl.md
Name: fetch_dispatch_ctrl

Overview:
Instruction fetch/decode sequencer that sits directly upstream of the per-opcode execution FSMs, including the immediate-data ALU operation controller. It owns the program counter and fetches an instruction word from program memory into an instruction register. It decodes the opcode, pulses a one-hot start to the matching execution FSM, then waits for that FSM's Done before fetching again. PC_Increment pulses from the execution FSMs (operand-word consumption) advance the PC while an instruction executes.

Parameters:
ADDR_W, 8, program-counter / program-memory address width
INSTR_W, 16, instruction word width; opcode is ir[INSTR_W-1:INSTR_W-4]
NUM_OPS, 4, number of execution FSMs (width of op_start)
WDOG_MAX, 255, EXEC cycle limit (used only with watchdog feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = sequencer may leave IDLE
mem_rd  out  1  program-memory read request, held until mem_valid
pc_addr  out  ADDR_W  current PC, drives program-memory address
mem_data  in  INSTR_W  program-memory read data, valid with mem_valid
mem_valid  in  1  read-data-valid; latency ≥1 cycle after mem_rd
ir  out  INSTR_W  instruction register
op_start  out  NUM_OPS  one-hot, one-cycle start pulse to an execution FSM
op_done  in  1  OR of all execution-FSM Done outputs
pc_inc  in  1  OR of execution-FSM PC_Increment outputs
halted  out  1  sequencer in HALT
illegal  out  1  sticky; undefined opcode seen

Behaviour:
- Reset (async, reset=0): state=IDLE, pc_addr=0, ir=0, mem_rd=0, op_start=0, halted=0, illegal=0.
- Opcode map: 0 NOP; 1 ALU_IMM→op_start[0]; 2 ALU_REG→[1]; 3 LOAD→[2]; 4 STORE→[3]; F HALT; all others illegal.
- States:
  - IDLE: run=1 → FETCH.
  - FETCH: mem_rd=1 → WAIT_MEM.
  - WAIT_MEM: mem_rd stays 1. On mem_valid: ir←mem_data, pc←pc+1, → DECODE.
  - DECODE (1 cycle):
    - NOP → FETCH (or IDLE if run=0).
    - HALT → HALT.
    - Illegal → set illegal, → HALT.
    - Otherwise → DISPATCH.
  - DISPATCH: op_start[idx]=1 for exactly this cycle → EXEC.
  - EXEC: each cycle with pc_inc=1, pc←pc+1. On op_done → FETCH if run=1, else IDLE.
  - HALT: halted=1. Only reset exits.
- op_done and pc_inc in the same cycle: both take effect (PC increments, then FETCH).
- op_done or pc_inc outside EXEC is ignored.
- PC wraps modulo 2^ADDR_W; no flag is raised.
- run deasserted mid-instruction: the current instruction completes; the stop takes effect only at the FETCH decision points.
- Minimum fetch-to-start latency, mem_valid one cycle after mem_rd: FETCH, WAIT_MEM, DECODE, DISPATCH, so op_start fires 4 cycles after FETCH entry.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

Optional Feature:
FDC_WATCHDOG_EN:
- Defined: an 8-bit counter clears on DISPATCH and increments each EXEC cycle. If it reaches WDOG_MAX without op_done, illegal is set and the sequencer enters HALT.
- Undefined: no counter exists, and EXEC waits indefinitely.

Decomposition:
- Shared package mc_pkg: state enum (IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, EXEC, HALT); opcode constants OPC_NOP, OPC_ALU_IMM, OPC_ALU_REG, OPC_LOAD, OPC_STORE, OPC_HALT; opcode-to-one-hot mapping constant. The mapping is shared with the execution FSMs.
- One sub-module: pc_counter (loadable ADDR_W counter with inc and async active-low clear).
- Decode stays inline.

Test Plan:
- Reset mid-EXEC (reset=0 for 1 cycle) → pc_addr=0, op_start=0, state IDLE immediately, without waiting for a clock edge.
- mem[0]=0x1005, run=1, 1-cycle memory → op_start=4'b0001 exactly 4 cycles after FETCH entry. Then a pc_inc pulse and op_done 3 cycles later → pc_addr=2, next mem_rd asserted.
- mem[0]=0x0000 (NOP), mem[1]=0x4000 → no op_start for the NOP; op_start=4'b1000 for the STORE; pc_addr=2 after its op_done.
- mem[0]=0x7ABC → illegal=1, halted=1, no op_start. Subsequent run toggling and op_done pulses → no change.
- pc_addr=0xFF with ALU_IMM at 0xFF plus one pc_inc → pc_addr wraps to 0x00 then 0x01; with pc_inc and op_done in the same cycle → both honored.
- With FDC_WATCHDOG_EN: op_done withheld for 255 EXEC cycles → illegal=1, halted=1. Without the macro: sequencer is still in EXEC at cycle 300.
